// File: rtl/lfsr_tap_loader_if.sv
// -----------------------------------------------------------------------------
// lfsr_tap_loader_if
//   Valid/ready offer channel that carries a finished tap polynomial from the
//   tap loader to the LFSR core.
//
//   Signals:
//     taps        WIDTH  assembled polynomial, meaningful only while taps_valid=1
//     taps_valid  1      loader is offering taps
//     taps_ready  1      core accepts; a transfer happens on an edge where
//                        taps_valid & taps_ready
//
//   Modports:
//     master  loader side (drives taps/taps_valid, samples taps_ready)
//     slave   core side   (samples taps/taps_valid, drives taps_ready)
// -----------------------------------------------------------------------------
interface lfsr_tap_loader_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] taps;
   logic             taps_valid;
   logic             taps_ready;

   modport master (
      output taps,
      output taps_valid,
      input  taps_ready
   );

   modport slave (
      input  taps,
      input  taps_valid,
      output taps_ready
   );
endinterface

// File: rtl/lfsr_tap_loader.sv
// -----------------------------------------------------------------------------
// lfsr_tap_loader
//   Builds a WIDTH-bit LFSR tap polynomial from 4-bit nibbles strobed in on
//   slow asynchronous pins (MSB nibble first). A completed all-zero word is
//   discarded because it would lock the LFSR. A non-zero word is offered to
//   the core over a valid/ready handshake so taps can change at run time.
//
//   Parameters:
//     WIDTH         tap word width, multiple of 4, 8..32
//     DEFAULT_TAPS  taps value after reset
//
//   Ports:
//     clk        in   system clock
//     rst_n      in   asynchronous active-low reset
//     clear      in   synchronous abort back to IDLE (already in clk domain)
//     strobe_in  in   asynchronous pin, each rising edge delivers a nibble
//     nibble_in  in   asynchronous pins, stable while strobe_in is high
//     tap_if     master side of the taps/taps_valid/taps_ready channel
//     busy       out  state is not IDLE (combinational from state)
//     zero_err   out  sticky: last completed word was zero and was discarded
//     overrun    out  sticky: a strobe arrived during OFFER and was dropped
// -----------------------------------------------------------------------------
module lfsr_tap_loader #(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] DEFAULT_TAPS = WIDTH'(16'hB400)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   input  logic                      strobe_in,
   input  logic [3:0]                nibble_in,
   lfsr_tap_loader_if.master         tap_if,
   output logic                      busy,
   output logic                      zero_err,
   output logic                      overrun
);

   localparam int N     = WIDTH / 4;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
   localparam logic [1:0] ST_OFFER   = 2'd2;

   // Synchronizers: two flops per pin, plus a third on strobe for edge detect.
   logic       strb_s1_q, strb_s2_q, strb_s3_q;
   logic [3:0] nib_s1_q, nib_s2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strb_s1_q <= 1'b0;
         strb_s2_q <= 1'b0;
         strb_s3_q <= 1'b0;
         nib_s1_q  <= 4'h0;
         nib_s2_q  <= 4'h0;
      end else begin
         strb_s1_q <= strobe_in;
         strb_s2_q <= strb_s1_q;
         strb_s3_q <= strb_s2_q;
         nib_s1_q  <= nibble_in;
         nib_s2_q  <= nib_s1_q;
      end
   end

   logic       strb_edge;
   logic [3:0] nib;

   assign strb_edge = strb_s2_q & ~strb_s3_q;
   assign nib       = nib_s2_q;

   // Collection state. Only the first N-1 nibbles are ever held: the last
   // nibble goes straight into the finished word, so the shift register is
   // WIDTH-4 bits and {shift, nib} is always the full candidate word.
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-5:0] shift_q, shift_d;
   logic [WIDTH-1:0] taps_q, taps_d;
   logic             valid_q, valid_d;
   logic             zero_err_q, zero_err_d;
   logic             overrun_q, overrun_d;
   logic [WIDTH-1:0] word;

   assign word = {shift_q, nib};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      taps_d     = taps_q;
      valid_d    = valid_q;
      zero_err_d = zero_err_q;
      overrun_d  = overrun_q;

      if (clear) begin
         // clear beats a simultaneous strobe edge (nibble dropped, no overrun)
         // and, in OFFER, a simultaneous ready still counts as a transfer
         // since valid is dropped either way. taps and zero_err survive.
         state_d   = ST_IDLE;
         cnt_d     = '0;
         shift_d   = '0;
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (strb_edge) begin
                  shift_d    = word[WIDTH-5:0];
                  cnt_d      = CNT_W'(1);
                  zero_err_d = 1'b0;
                  state_d    = ST_COLLECT;
               end
            end

            ST_COLLECT: begin
               if (strb_edge) begin
                  if (cnt_q != CNT_W'(N - 1)) begin
                     shift_d = word[WIDTH-5:0];
                     cnt_d   = cnt_q + CNT_W'(1);
                  end else begin
                     cnt_d = '0;
                     if (word != '0) begin
                        taps_d  = word;
                        valid_d = 1'b1;
                        state_d = ST_OFFER;
                     end else begin
                        zero_err_d = 1'b1;
                        state_d    = ST_IDLE;
                     end
                  end
               end
            end

            ST_OFFER: begin
               // Ready and a strobe edge on the same cycle: the transfer
               // completes and the nibble is still reported as overrun.
               if (tap_if.taps_ready) begin
                  valid_d = 1'b0;
                  state_d = ST_IDLE;
               end
               if (strb_edge) begin
                  overrun_d = 1'b1;
               end
            end

            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         taps_q     <= DEFAULT_TAPS;
         valid_q    <= 1'b0;
         zero_err_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         taps_q     <= taps_d;
         valid_q    <= valid_d;
         zero_err_q <= zero_err_d;
         overrun_q  <= overrun_d;
      end
   end

   assign tap_if.taps       = taps_q;
   assign tap_if.taps_valid = valid_q;
   assign busy              = (state_q != ST_IDLE);
   assign zero_err          = zero_err_q;
   assign overrun           = overrun_q;

endmodule

// File: tb/tb_lfsr_tap_loader.sv
// -----------------------------------------------------------------------------
// tb_lfsr_tap_loader
//   Directed bench for lfsr_tap_loader with WIDTH=16, DEFAULT_TAPS=16'hB400.
//   Pins are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_lfsr_tap_loader;

   localparam int WIDTH = 16;

   logic       clk;
   logic       rst_n;
   logic       clear;
   logic       strobe_in;
   logic [3:0] nibble_in;
   logic       busy;
   logic       zero_err;
   logic       overrun;

   int n_checks;
   int n_errors;

   lfsr_tap_loader_if #(.WIDTH(WIDTH)) tap_if ();

   lfsr_tap_loader #(
      .WIDTH        (WIDTH),
      .DEFAULT_TAPS (16'hB400)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .strobe_in (strobe_in),
      .nibble_in (nibble_in),
      .tap_if    (tap_if),
      .busy      (busy),
      .zero_err  (zero_err),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One nibble: strobe high 2 clk, low 3 clk. Capture happens on the third
   // rising edge after the pin rise, so it is complete when this returns.
   task automatic send_nibble(input logic [3:0] n);
      @(negedge clk);
      strobe_in = 1'b1;
      nibble_in = n;
      repeat (2) @(negedge clk);
      strobe_in = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // Final nibble with the latency checked edge by edge.
   task automatic send_last(input logic [3:0] n, input logic [15:0] exp_taps, input string tag);
      @(negedge clk);
      strobe_in = 1'b1;
      nibble_in = n;
      @(negedge clk);
      check({tag, "_valid_e1"}, 32'(tap_if.taps_valid), 32'd0);
      @(negedge clk);
      check({tag, "_valid_e2"}, 32'(tap_if.taps_valid), 32'd0);
      strobe_in = 1'b0;
      @(negedge clk);
      check({tag, "_valid_e3"}, 32'(tap_if.taps_valid), 32'd1);
      check({tag, "_taps"}, 32'(tap_if.taps), 32'(exp_taps));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic accept();
      @(negedge clk);
      tap_if.taps_ready = 1'b1;
      @(negedge clk);
      tap_if.taps_ready = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      n_checks          = 0;
      n_errors          = 0;
      rst_n             = 1'b0;
      clear             = 1'b0;
      strobe_in         = 1'b0;
      nibble_in         = 4'h0;
      tap_if.taps_ready = 1'b0;

      // Reset held with pins toggling
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         strobe_in = ~strobe_in;
         nibble_in = 4'(i + 5);
      end
      check("rst_taps",     32'(tap_if.taps),       32'hB400);
      check("rst_valid",    32'(tap_if.taps_valid), 32'd0);
      check("rst_busy",     32'(busy),              32'd0);
      check("rst_zero_err", 32'(zero_err),          32'd0);
      check("rst_overrun",  32'(overrun),           32'd0);
      strobe_in = 1'b0;
      nibble_in = 4'h0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("post_rst_taps", 32'(tap_if.taps), 32'hB400);
      check("post_rst_busy", 32'(busy),        32'd0);

      // taps_ready while idle is ignored
      accept();
      check("idle_ready_busy",  32'(busy),              32'd0);
      check("idle_ready_valid", 32'(tap_if.taps_valid), 32'd0);

      // Normal load D,0,0,8
      send_nibble(4'hD);
      check("load_busy_n1", 32'(busy), 32'd1);
      send_nibble(4'h0);
      send_nibble(4'h0);
      check("load_valid_n3", 32'(tap_if.taps_valid), 32'd0);
      send_last(4'h8, 16'hD008, "load");
      repeat (5) @(negedge clk);
      check("load_hold_valid", 32'(tap_if.taps_valid), 32'd1);
      check("load_hold_taps",  32'(tap_if.taps),       32'hD008);
      accept();
      check("load_acc_valid", 32'(tap_if.taps_valid), 32'd0);
      check("load_acc_busy",  32'(busy),              32'd0);
      check("load_acc_taps",  32'(tap_if.taps),       32'hD008);

      // Zero word rejected
      for (int i = 0; i < 4; i++) begin
         send_nibble(4'h0);
         check("zero_valid", 32'(tap_if.taps_valid), 32'd0);
      end
      check("zero_err_set", 32'(zero_err),    32'd1);
      check("zero_taps",    32'(tap_if.taps), 32'hD008);
      check("zero_busy",    32'(busy),        32'd0);
      send_nibble(4'h1);
      check("zero_err_clr", 32'(zero_err), 32'd0);
      send_nibble(4'h2);
      send_nibble(4'h3);
      send_last(4'h4, 16'h1234, "w1234");

      // Overrun during OFFER of 1234
      send_nibble(4'hF);
      check("ovr_set",   32'(overrun),           32'd1);
      check("ovr_taps",  32'(tap_if.taps),       32'h1234);
      check("ovr_valid", 32'(tap_if.taps_valid), 32'd1);
      accept();
      check("ovr_acc_valid",  32'(tap_if.taps_valid), 32'd0);
      check("ovr_sticky",     32'(overrun),           32'd1);
      pulse_clear();
      check("ovr_clr",        32'(overrun),           32'd0);
      check("ovr_clr_taps",   32'(tap_if.taps),       32'h1234);

      // Abort after three nibbles
      send_nibble(4'h7);
      send_nibble(4'h7);
      send_nibble(4'h7);
      check("abort_busy_pre", 32'(busy), 32'd1);
      pulse_clear();
      check("abort_busy",  32'(busy),              32'd0);
      check("abort_valid", 32'(tap_if.taps_valid), 32'd0);
      send_nibble(4'hA);
      send_nibble(4'hB);
      send_nibble(4'hC);
      send_last(4'hD, 16'hABCD, "abcd");
      accept();
      check("abcd_acc_valid", 32'(tap_if.taps_valid), 32'd0);

      // Async reset mid-offer
      send_nibble(4'h5);
      send_nibble(4'h6);
      send_nibble(4'h7);
      send_last(4'h8, 16'h5678, "w5678");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(tap_if.taps_valid), 32'd0);
      check("arst_taps",  32'(tap_if.taps),       32'hB400);
      check("arst_busy",  32'(busy),              32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
